// File: rtl/jh512_ctrl.sv
// rtl/jh512_ctrl.sv - JH512 sequencer: packs 128-bit words into 512-bit blocks,
// chains the 1024-bit state through the core and presents the 512-bit digest.
module jh512_ctrl #(
  parameter logic [1023:0] IV = {
    128'h4bdd8ccc78465a54fb1785e6dffcc2e3,
    128'h56b116577c8806a756f8b19decf657cf,
    128'h99c15a2db1716e3b243c84c1d0a74710,
    128'h5ae66f2e8e8ab546694ae34105e66901,
    128'hf73bf8ba763a0fa9a6ba7520dbcc8e58,
    128'h806d2bea6b05a92a1e806f53c1a01d89,
    128'h61c3b3f2591234e90bef970c8d5e228a,
    128'h43d5157a052e6a6317aa003e964bd16f
  },
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             msg_valid,
  output logic             msg_ready,
  input  logic [127:0]     msg_data,
  input  logic             msg_last,
  output logic             core_start,
  output logic [1023:0]    core_state,
  output logic [511:0]     core_msg,
  input  logic             core_done,
  input  logic [1023:0]    core_result,
  output logic             hash_valid,
  output logic [511:0]     hash,
  input  logic             hash_ready,
  output logic             busy,
  output logic             error,
  output logic [CNT_W-1:0] blk_cnt
);

  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, OUT} state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t        state, state_nxt;
  logic [1:0]    widx;
  logic [1:0]    wsel;
  logic          last_blk;
  logic [15:0]   tmo_cnt;
  logic [1023:0] chain;
  logic          msg_begin, word_store, blk_done, err_set;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    msg_begin  = 1'b0;
    word_store = 1'b0;
    blk_done   = 1'b0;
    err_set    = 1'b0;
    msg_ready  = 1'b0;
    core_start = 1'b0;
    hash_valid = 1'b0;
    unique case (state)
      IDLE: begin
        msg_ready = 1'b1;
        if (msg_valid) begin
          msg_begin  = 1'b1;
          word_store = 1'b1;
          // A one-word "message" can never fill a block: flag it and stay put.
          if (msg_last) err_set   = 1'b1;
          else          state_nxt = LOAD;
        end
      end
      LOAD: begin
        msg_ready = 1'b1;
        if (msg_valid) begin
          word_store = 1'b1;
          if (widx == 2'd3) begin
            state_nxt = START;
          end else if (msg_last) begin
            err_set   = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      START: begin
        core_start = 1'b1;
        state_nxt  = WAIT;
      end
      WAIT: begin
        if (core_done) begin
          blk_done  = 1'b1;
          state_nxt = last_blk ? OUT : LOAD;
        end else if (tmo_cnt == TMO_LAST) begin
          err_set   = 1'b1;
          state_nxt = IDLE;
        end
      end
      OUT: begin
        hash_valid = 1'b1;
        if (hash_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy       = (state != IDLE);
  assign core_state = chain;
  assign hash       = hash_valid ? chain[511:0] : 512'd0;
  assign wsel       = msg_begin ? 2'd0 : widx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      widx     <= 2'd0;
      last_blk <= 1'b0;
      tmo_cnt  <= 16'd0;
      chain    <= IV;
      core_msg <= 512'd0;
      blk_cnt  <= '0;
      error    <= 1'b0;
    end else begin
      if (msg_begin)       widx <= 2'd1;
      else if (word_store) widx <= widx + 2'd1;
      else if (blk_done)   widx <= 2'd0;

      // Word 0 is the most significant quarter of the block.
      if (word_store) begin
        case (wsel)
          2'd0:    core_msg[511:384] <= msg_data;
          2'd1:    core_msg[383:256] <= msg_data;
          2'd2:    core_msg[255:128] <= msg_data;
          default: core_msg[127:0]   <= msg_data;
        endcase
      end

      if (word_store && state == LOAD && widx == 2'd3) last_blk <= msg_last;

      tmo_cnt <= (state == WAIT) ? tmo_cnt + 16'd1 : 16'd0;

      if (msg_begin)     chain <= IV;
      else if (blk_done) chain <= core_result;

      if (msg_begin)                     blk_cnt <= '0;
      else if (blk_done && blk_cnt != '1) blk_cnt <= blk_cnt + 1'b1;

      if (err_set)        error <= 1'b1;
      else if (msg_begin) error <= 1'b0;
    end
  end

endmodule

// File: tb/tb_jh512_ctrl.sv
// tb/tb_jh512_ctrl.sv - randomized bench for jh512_ctrl with a block-level
// reference model of the chaining and a behavioural core stand-in.
module tb_jh512_ctrl;

  localparam logic [1023:0] IV = {
    128'h4bdd8ccc78465a54fb1785e6dffcc2e3,
    128'h56b116577c8806a756f8b19decf657cf,
    128'h99c15a2db1716e3b243c84c1d0a74710,
    128'h5ae66f2e8e8ab546694ae34105e66901,
    128'hf73bf8ba763a0fa9a6ba7520dbcc8e58,
    128'h806d2bea6b05a92a1e806f53c1a01d89,
    128'h61c3b3f2591234e90bef970c8d5e228a,
    128'h43d5157a052e6a6317aa003e964bd16f
  };

  logic          clk, rst_n;
  logic          msg_valid, msg_ready, msg_last;
  logic [127:0]  msg_data;
  logic          core_start, core_done;
  logic [1023:0] core_state, core_result;
  logic [511:0]  core_msg;
  logic          hash_valid, hash_ready;
  logic [511:0]  hash;
  logic          busy, error;
  logic [15:0]   blk_cnt;

  jh512_ctrl #(.IV(IV), .TIMEOUT(8), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_data(msg_data), .msg_last(msg_last),
    .core_start(core_start), .core_state(core_state), .core_msg(core_msg),
    .core_done(core_done), .core_result(core_result),
    .hash_valid(hash_valid), .hash(hash), .hash_ready(hash_ready),
    .busy(busy), .error(error), .blk_cnt(blk_cnt)
  );

  int errors = 0;
  int checks = 0;

  logic [127:0]  tx_words[$];
  bit            tx_last[$];
  logic [1023:0] mon_state_q[$];
  logic [511:0]  mon_msg_q[$];
  bit            core_en = 1'b1;
  bit            pending = 1'b0;
  int            ready_viol = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the compression function: any mixing of state and block works.
  function automatic logic [1023:0] core_f(input logic [1023:0] s, input logic [511:0] m);
    return s ^ {m, m[255:0], m[511:256]} ^ 1024'd1;
  endfunction

  initial begin
    logic [1023:0] s;
    logic [511:0]  m;
    int            lat;
    core_done   = 1'b0;
    core_result = '0;
    forever begin
      @(negedge clk);
      if (core_en && rst_n && core_start) begin
        s   = core_state;
        m   = core_msg;
        lat = $urandom_range(1, 5);
        repeat (lat) @(negedge clk);
        if (core_en && rst_n) begin
          core_done   = 1'b1;
          core_result = core_f(s, m);
          @(negedge clk);
          core_done   = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && core_start) begin
      mon_state_q.push_back(core_state);
      mon_msg_q.push_back(core_msg);
    end
    if (rst_n && ((pending && msg_ready) || (hash_valid && msg_ready))) ready_viol++;
  end

  always @(posedge clk) begin
    if (!rst_n)          pending = 1'b0;
    else if (core_start) pending = 1'b1;
    else if (core_done)  pending = 1'b0;
    else if (!busy)      pending = 1'b0;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1);
  end

  task automatic send_words(input int gap_pct, output bit ok);
    bit r;
    int tries;
    ok = 1'b1;
    for (int i = 0; i < tx_words.size(); i++) begin
      while ($urandom_range(0, 99) < gap_pct) begin
        msg_valid = 1'b0;
        @(negedge clk);
      end
      msg_valid = 1'b1;
      msg_data  = tx_words[i];
      msg_last  = tx_last[i];
      tries = 0;
      do begin
        r = msg_ready;
        @(negedge clk);
        tries++;
      end while (!r && tries < 300);
      if (!r) begin
        errors++; checks++;
        $display("FAIL send_timeout: word %0d never accepted, msg_ready=%0b required 1", i, msg_ready);
        ok = 1'b0;
        break;
      end
    end
    msg_valid = 1'b0;
    msg_last  = 1'b0;
  endtask

  task automatic run_message(input string tag, input int nblk, input bit zero,
                             input int gap_pct, input int stall);
    logic [1023:0] ch;
    logic [511:0]  blk;
    logic [1023:0] exp_state[$];
    logic [511:0]  exp_msg[$];
    bit            ok, stable;
    int            tries;
    tx_words.delete(); tx_last.delete();
    for (int i = 0; i < 4 * nblk; i++) begin
      tx_words.push_back(zero ? 128'd0 : {$urandom(), $urandom(), $urandom(), $urandom()});
      tx_last.push_back(i == 4 * nblk - 1);
    end
    ch = IV;
    for (int b = 0; b < nblk; b++) begin
      blk = {tx_words[4*b], tx_words[4*b+1], tx_words[4*b+2], tx_words[4*b+3]};
      exp_state.push_back(ch);
      exp_msg.push_back(blk);
      ch = core_f(ch, blk);
    end
    mon_state_q.delete(); mon_msg_q.delete();
    ready_viol = 0;
    send_words(gap_pct, ok);
    if (!ok) return;
    checks++;
    if (core_start !== 1'b1) begin
      errors++;
      $display("FAIL %s start_latency: core_start=%0b required 1 one cycle after last word", tag, core_start);
    end
    tries = 0;
    while (hash_valid !== 1'b1 && tries < 500) begin
      @(negedge clk);
      tries++;
    end
    checks++;
    if (hash_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s hash_timeout: hash_valid=%0b required 1", tag, hash_valid);
      return;
    end
    checks++;
    if (hash !== ch[511:0]) begin
      errors++;
      $display("FAIL %s hash: got %h required %h", tag, hash, ch[511:0]);
    end
    checks++;
    if (blk_cnt !== 16'(nblk)) begin
      errors++;
      $display("FAIL %s blk_cnt: got %0d required %0d", tag, blk_cnt, nblk);
    end
    stable = 1'b1;
    repeat (stall) begin
      @(negedge clk);
      if (hash_valid !== 1'b1 || hash !== ch[511:0] || msg_ready !== 1'b0) stable = 1'b0;
    end
    checks++;
    if (!stable) begin
      errors++;
      $display("FAIL %s hash_hold: stall=%0d hash_valid=%0b msg_ready=%0b required 1/0 and stable hash",
               tag, stall, hash_valid, msg_ready);
    end
    hash_ready = 1'b1;
    @(negedge clk);
    hash_ready = 1'b0;
    checks++;
    if (hash_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s release: hash_valid=%0b busy=%0b required 0/0", tag, hash_valid, busy);
    end
    checks++;
    if (mon_state_q.size() != nblk) begin
      errors++;
      $display("FAIL %s start_count: got %0d required %0d", tag, mon_state_q.size(), nblk);
    end else begin
      for (int b = 0; b < nblk; b++) begin
        checks++;
        if (mon_state_q[b] !== exp_state[b] || mon_msg_q[b] !== exp_msg[b]) begin
          errors++;
          $display("FAIL %s block%0d: state %h msg %h required state %h msg %h",
                   tag, b, mon_state_q[b][127:0], mon_msg_q[b], exp_state[b][127:0], exp_msg[b]);
        end
      end
    end
    checks++;
    if (ready_viol != 0) begin
      errors++;
      $display("FAIL %s ready_low: %0d cycles with msg_ready=1 while busy with core/digest, required 0",
               tag, ready_viol);
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({msg_ready, core_start, hash_valid, error, busy} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_flags: ready/start/hv/err/busy=%b required 10000",
               {msg_ready, core_start, hash_valid, error, busy});
    end
    checks++;
    if (blk_cnt !== 16'd0 || core_msg !== 512'd0 || hash !== 512'd0) begin
      errors++;
      $display("FAIL reset_data: blk_cnt=%0d core_msg=%h hash=%h required zeros", blk_cnt, core_msg, hash);
    end
    checks++;
    if (core_state !== IV) begin
      errors++;
      $display("FAIL reset_state: core_state=%h required IV", core_state);
    end
  endtask

  task automatic test_single_block();
    run_message("single", 1, 1'b1, 0, 10);
  endtask

  task automatic test_chain();
    run_message("chain3", 3, 1'b0, 0, 2);
  endtask

  task automatic test_backpressure();
    for (int n = 0; n < 4; n++)
      run_message("bp", $urandom_range(1, 3), 1'b0, 40, $urandom_range(0, 6));
  endtask

  task automatic test_early_last();
    bit ok;
    tx_words.delete(); tx_last.delete();
    tx_words.push_back({$urandom(), $urandom(), $urandom(), $urandom()}); tx_last.push_back(1'b0);
    tx_words.push_back({$urandom(), $urandom(), $urandom(), $urandom()}); tx_last.push_back(1'b1);
    mon_state_q.delete(); mon_msg_q.delete();
    send_words(0, ok);
    repeat (6) @(negedge clk);
    checks++;
    if (error !== 1'b1 || busy !== 1'b0 || msg_ready !== 1'b1) begin
      errors++;
      $display("FAIL early_last: error=%0b busy=%0b msg_ready=%0b required 1/0/1", error, busy, msg_ready);
    end
    checks++;
    if (mon_state_q.size() != 0) begin
      errors++;
      $display("FAIL early_last_start: %0d core_start pulses required 0", mon_state_q.size());
    end
    run_message("after_err", 1, 1'b0, 0, 0);
    checks++;
    if (error !== 1'b0) begin
      errors++;
      $display("FAIL err_clear: error=%0b required 0 after new message", error);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    core_en = 1'b0;
    tx_words.delete(); tx_last.delete();
    for (int i = 0; i < 4; i++) begin
      tx_words.push_back({$urandom(), $urandom(), $urandom(), $urandom()});
      tx_last.push_back(i == 3);
    end
    send_words(0, ok);
    repeat (8) @(negedge clk);
    checks++;
    if (error !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL timeout_early: error=%0b busy=%0b required 0/1 in 8th WAIT cycle", error, busy);
    end
    @(negedge clk);
    checks++;
    if (error !== 1'b1 || busy !== 1'b0 || msg_ready !== 1'b1 || hash_valid !== 1'b0) begin
      errors++;
      $display("FAIL timeout: error=%0b busy=%0b msg_ready=%0b hash_valid=%0b required 1/0/1/0",
               error, busy, msg_ready, hash_valid);
    end
    core_en = 1'b1;
  endtask

  task automatic test_async_reset();
    bit ok, quiet;
    core_en = 1'b0;
    tx_words.delete(); tx_last.delete();
    for (int i = 0; i < 4; i++) begin
      tx_words.push_back({$urandom(), $urandom(), $urandom(), $urandom()});
      tx_last.push_back(i == 3);
    end
    mon_state_q.delete(); mon_msg_q.delete();
    send_words(0, ok);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({msg_ready, core_start, hash_valid, error, busy} !== 5'b10000 || blk_cnt !== 16'd0) begin
      errors++;
      $display("FAIL async_reset_flags: ready/start/hv/err/busy=%b blk_cnt=%0d required 10000/0",
               {msg_ready, core_start, hash_valid, error, busy}, blk_cnt);
    end
    checks++;
    if (core_state !== IV || core_msg !== 512'd0 || hash !== 512'd0) begin
      errors++;
      $display("FAIL async_reset_data: core_state/core_msg/hash not at reset values");
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    core_done   = 1'b1;
    core_result = {32{$urandom()}};
    @(negedge clk);
    core_done = 1'b0;
    quiet = 1'b1;
    repeat (6) begin
      if (hash_valid !== 1'b0 || busy !== 1'b0 || core_start !== 1'b0) quiet = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (!quiet || core_state !== IV || blk_cnt !== 16'd0) begin
      errors++;
      $display("FAIL stale_done: quiet=%0b blk_cnt=%0d core_state_is_iv=%0b required 1/0/1",
               quiet, blk_cnt, core_state === IV);
    end
    checks++;
    if (mon_state_q.size() != 1) begin
      errors++;
      $display("FAIL reset_starts: %0d core_start pulses required 1", mon_state_q.size());
    end
    core_en = 1'b1;
  endtask

  initial begin
    rst_n      = 1'b0;
    msg_valid  = 1'b0;
    msg_last   = 1'b0;
    msg_data   = '0;
    hash_ready = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_single_block();
    test_chain();
    test_backpressure();
    test_early_last();
    test_timeout();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
